// File: rtl/mantissa_align_add.sv
// mantissa_align_add
//   Back end of the FP32 adder/subtractor. Takes the hidden-bit mantissas of the
//   larger-exponent operand (nonShifted_val) and the smaller operand (Shifted_val,
//   still unaligned), the larger biased exponent and the exponent difference, then
//   aligns, adds/subtracts, normalizes, rounds to nearest-even and packs an
//   IEEE-754 single. Three-stage valid/ready pipeline: align -> add -> norm/round.
//
// Ports
//   clk, rstn            clock (rising edge), async active-low reset
//   in_valid / in_ready  input handshake
//   nonShifted_val       {1,frac} of larger-exponent operand
//   Shifted_val          {1,frac} of smaller operand, unshifted
//   exponent_temp        larger biased exponent
//   exp_diff             unsigned exponent difference
//   sign_big, eff_sub    sign of larger operand, 1 = effective subtraction
//   out_valid/out_ready  output handshake
//   result               packed {sign, exp, frac}
module mantissa_align_add #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MAN_W:0]     nonShifted_val,
    input  logic [MAN_W:0]     Shifted_val,
    input  logic [EXP_W-1:0]   exponent_temp,
    input  logic [EXP_W-1:0]   exp_diff,
    input  logic               sign_big,
    input  logic               eff_sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [EXP_W+MAN_W:0] result
);
    // EW: mantissa plus guard/round/sticky; SW: one extra carry bit
    localparam int EW  = MAN_W + 4;
    localparam int SW  = EW + 1;
    localparam int LZW = $clog2(EW + 1);
    localparam int XW  = EXP_W + 2;

    logic stall;

    logic               s1_valid_q, s1_valid_d;
    logic [EW-1:0]      s1_big_q, s1_big_d;
    logic [EW-1:0]      s1_aligned_q, s1_aligned_d;
    logic [EXP_W-1:0]   s1_exp_q, s1_exp_d;
    logic               s1_sign_q, s1_sign_d;
    logic               s1_sub_q, s1_sub_d;

    logic               s2_valid_q, s2_valid_d;
    logic [SW-1:0]      s2_sum_q, s2_sum_d;
    logic [EXP_W-1:0]   s2_exp_q, s2_exp_d;
    logic               s2_sign_q, s2_sign_d;

    logic               s3_valid_q, s3_valid_d;
    logic [EXP_W+MAN_W:0] s3_result_q, s3_result_d;

    logic [EW-1:0]      ext, shifted, lost_mask;
    logic               sticky;
    logic [SW-1:0]      big_x, al_x, sum_c;
    logic               sign_c;
    logic [LZW-1:0]     lz;
    logic               lz_found;
    logic [EW-1:0]      norm;
    logic [XW-1:0]      exp_n, exp_r;
    logic [MAN_W:0]     mant;
    logic               round_up;
    logic [MAN_W+1:0]   mant_r;
    logic [MAN_W-1:0]   frac;
    logic [EXP_W+MAN_W:0] res_c;

    assign stall     = s3_valid_q & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = s3_valid_q;
    assign result    = s3_result_q;

    // Stage 1: right-align the smaller mantissa, folding shifted-out bits into S
    always_comb begin
        ext       = {Shifted_val, 3'b000};
        shifted   = '0;
        lost_mask = '0;
        sticky    = 1'b0;
        if (exp_diff >= EXP_W'(EW)) begin
            sticky = |Shifted_val;
        end else begin
            shifted   = ext >> exp_diff;
            lost_mask = ~({EW{1'b1}} << exp_diff);
            sticky    = |(ext & lost_mask);
        end
    end

    // Stage 2: add or subtract; a negative difference (only when exp_diff = 0)
    // is computed the other way round with the sign flipped
    always_comb begin
        big_x  = {1'b0, s1_big_q};
        al_x   = {1'b0, s1_aligned_q};
        sign_c = s1_sign_q;
        if (!s1_sub_q) begin
            sum_c = big_x + al_x;
        end else if (s1_big_q < s1_aligned_q) begin
            sum_c  = al_x - big_x;
            sign_c = ~s1_sign_q;
        end else begin
            sum_c = big_x - al_x;
        end
    end

    // Stage 3: normalize, round to nearest-even, pack with overflow/flush handling
    always_comb begin
        lz       = LZW'(EW);
        lz_found = 1'b0;
        for (int i = EW - 1; i >= 0; i--) begin
            if (!lz_found && s2_sum_q[i]) begin
                lz       = LZW'(EW - 1 - i);
                lz_found = 1'b1;
            end
        end

        if (s2_sum_q[SW-1]) begin
            norm  = {s2_sum_q[SW-1:2], s2_sum_q[1] | s2_sum_q[0]};
            exp_n = {2'b00, s2_exp_q} + XW'(1);
        end else begin
            norm  = s2_sum_q[EW-1:0] << lz;
            exp_n = {2'b00, s2_exp_q} - XW'(lz);
        end

        mant     = norm[EW-1:3];
        round_up = norm[2] & (norm[1] | norm[0] | mant[0]);
        mant_r   = {1'b0, mant} + (MAN_W+2)'(round_up);

        // rounding carried out of the hidden bit: mantissa becomes 1.000...
        if (mant_r[MAN_W+1]) begin
            frac  = mant_r[MAN_W:1];
            exp_r = exp_n + XW'(1);
        end else begin
            frac  = mant_r[MAN_W-1:0];
            exp_r = exp_n;
        end

        if (s2_sum_q == '0) begin
            res_c = '0;
        end else if (!exp_r[XW-1] && (exp_r[XW-2:0] >= (XW-1)'(2**EXP_W - 1))) begin
            res_c = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (exp_r[XW-1] || (exp_r == '0)) begin
            res_c = {s2_sign_q, {(EXP_W+MAN_W){1'b0}}};
        end else begin
            res_c = {s2_sign_q, exp_r[EXP_W-1:0], frac};
        end
    end

    // Next-state: everything holds during a stall; data only loads with a valid
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_big_d     = s1_big_q;
        s1_aligned_d = s1_aligned_q;
        s1_exp_d     = s1_exp_q;
        s1_sign_d    = s1_sign_q;
        s1_sub_d     = s1_sub_q;
        s2_valid_d   = s2_valid_q;
        s2_sum_d     = s2_sum_q;
        s2_exp_d     = s2_exp_q;
        s2_sign_d    = s2_sign_q;
        s3_valid_d   = s3_valid_q;
        s3_result_d  = s3_result_q;
        if (!stall) begin
            s1_valid_d = in_valid;
            s2_valid_d = s1_valid_q;
            s3_valid_d = s2_valid_q;
            if (in_valid) begin
                s1_big_d     = {nonShifted_val, 3'b000};
                s1_aligned_d = {shifted[EW-1:1], shifted[0] | sticky};
                s1_exp_d     = exponent_temp;
                s1_sign_d    = sign_big;
                s1_sub_d     = eff_sub;
            end
            if (s1_valid_q) begin
                s2_sum_d  = sum_c;
                s2_exp_d  = s1_exp_q;
                s2_sign_d = sign_c;
            end
            if (s2_valid_q) begin
                s3_result_d = res_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q   <= 1'b0;
            s1_big_q     <= '0;
            s1_aligned_q <= '0;
            s1_exp_q     <= '0;
            s1_sign_q    <= 1'b0;
            s1_sub_q     <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_sum_q     <= '0;
            s2_exp_q     <= '0;
            s2_sign_q    <= 1'b0;
            s3_valid_q   <= 1'b0;
            s3_result_q  <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_big_q     <= s1_big_d;
            s1_aligned_q <= s1_aligned_d;
            s1_exp_q     <= s1_exp_d;
            s1_sign_q    <= s1_sign_d;
            s1_sub_q     <= s1_sub_d;
            s2_valid_q   <= s2_valid_d;
            s2_sum_q     <= s2_sum_d;
            s2_exp_q     <= s2_exp_d;
            s2_sign_q    <= s2_sign_d;
            s3_valid_q   <= s3_valid_d;
            s3_result_q  <= s3_result_d;
        end
    end

endmodule

// File: tb/tb_mantissa_align_add.sv
// tb_mantissa_align_add
//   Scoreboard bench: the expected result of every accepted operation is queued
//   at acceptance and compared, in order, whenever out_valid is seen.
module tb_mantissa_align_add;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] ns_val = '0;
    logic [23:0] sh_val = '0;
    logic [7:0]  exp_t = '0;
    logic [7:0]  exp_d = '0;
    logic        sign_big = 1'b0;
    logic        eff_sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;

    logic [31:0] cur_exp = '0;
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic        prev_stall = 1'b0;
    logic        rnd_done = 1'b0;
    int          lat;

    always #5 clk = ~clk;

    mantissa_align_add dut (
        .clk            (clk),
        .rstn           (rstn),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .nonShifted_val (ns_val),
        .Shifted_val    (sh_val),
        .exponent_temp  (exp_t),
        .exp_diff       (exp_d),
        .sign_big       (sign_big),
        .eff_sub        (eff_sub),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .result         (result)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp_v, $time);
        end
    endtask

    // Exact reference: form the true integer sum at a common scale, then
    // round-to-nearest-even the magnitude down to 24 significant bits.
    function automatic logic [31:0] ref_model(input logic [23:0] a, input logic [23:0] b,
                                              input logic [7:0] e, input logic [7:0] d,
                                              input logic sb, input logic sub);
        longint      x;
        logic [63:0] mag, m, rem, half;
        logic        s;
        int          p, sh, ex;
        x = longint'(a);
        x = x << d;
        if (sub) x = x - longint'(b);
        else     x = x + longint'(b);
        s = sb;
        if (x < 0) begin
            x = -x;
            s = ~sb;
        end
        if (x == 0) return 32'h0;
        mag = x;
        p = 0;
        for (int i = 0; i < 64; i++) if (mag[i]) p = i;
        sh = p - 23;
        if (sh > 0) begin
            m    = mag >> sh;
            rem  = mag & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && m[0])) m = m + 64'd1;
        end else begin
            m = mag << (-sh);
        end
        ex = int'(e) + sh - int'(d);
        if (m[24]) begin
            m = m >> 1;
            ex++;
        end
        if (ex >= 255) return {s, 8'hFF, 23'h0};
        if (ex <= 0) return {s, 31'h0};
        return {s, 8'(ex), m[22:0]};
    endfunction

    // Monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rstn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check_eq("stall_keeps_valid", {31'b0, out_valid}, 32'd1);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_out_valid", {31'b0, out_valid}, 32'd0);
                end else begin
                    check_eq("result", result, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            prev_stall = out_valid & ~out_ready;
            if (in_valid && in_ready) exp_q.push_back(cur_exp);
        end
    end

    task automatic send(input logic [23:0] a, input logic [23:0] b, input logic [7:0] e,
                        input logic [7:0] d, input logic sb, input logic sub,
                        input logic [31:0] expv);
        int   guard;
        logic acc;
        ns_val   = a;
        sh_val   = b;
        exp_t    = e;
        exp_d    = d;
        sign_big = sb;
        eff_sub  = sub;
        cur_exp  = expv;
        in_valid = 1'b1;
        guard    = 0;
        acc      = 1'b0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 100);
        if (!acc) check_eq("send_timeout", {31'b0, acc}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic send_m(input logic [23:0] a, input logic [23:0] b, input logic [7:0] e,
                          input logic [7:0] d, input logic sb, input logic sub);
        send(a, b, e, d, sb, sub, ref_model(a, b, e, d, sb, sub));
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check_eq("drain_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        // reset state
        #1;
        check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("rst_result", result, 32'h0);
        check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;

        // latency of a single 1.0 + 1.0
        ns_val = 24'h800000; sh_val = 24'h800000; exp_t = 8'd127; exp_d = 8'd0;
        sign_big = 1'b0; eff_sub = 1'b0; cur_exp = 32'h40000000; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("latency", lat, 32'd3);
        wait_drain();

        // directed values
        send(24'hC00000, 24'h800000, 8'd127, 8'd0,  1'b0, 1'b1, 32'h3F000000);
        send(24'h800000, 24'hC00000, 8'd127, 8'd0,  1'b0, 1'b1, 32'hBF000000);
        send(24'h800000, 24'h800000, 8'd127, 8'd0,  1'b0, 1'b1, 32'h00000000);
        send(24'h800000, 24'h800000, 8'd127, 8'd24, 1'b0, 1'b0, 32'h3F800000);
        send(24'h800000, 24'hC00000, 8'd127, 8'd24, 1'b0, 1'b0, 32'h3F800001);
        send(24'hFFFFFF, 24'hFFFFFF, 8'd254, 8'd0,  1'b0, 1'b0, 32'h7F800000);
        send(24'h800000, 24'hC00000, 8'd1,   8'd0,  1'b0, 1'b1, 32'h80000000);
        send_m(24'h800000, 24'h800001, 8'd100, 8'd27, 1'b1, 1'b1);
        send_m(24'hABCDEF, 24'hFFFFFF, 8'd60,  8'd30, 1'b1, 1'b0);
        send_m(24'h800001, 24'hFFFFFF, 8'd50,  8'd1,  1'b0, 1'b1);
        wait_drain();

        // backpressure: four back-to-back ops against a stalled output
        out_ready = 1'b0;
        fork
            begin
                send_m(24'h912345, 24'hA00000, 8'd130, 8'd3, 1'b0, 1'b0);
                send_m(24'hF00000, 24'h812345, 8'd90,  8'd5, 1'b1, 1'b1);
                send_m(24'hC0FFEE, 24'hC0FFEE, 8'd200, 8'd0, 1'b0, 1'b1);
                send_m(24'h87654F, 24'hEEEEEE, 8'd10,  8'd9, 1'b1, 1'b0);
            end
            begin
                repeat (6) @(posedge clk);
                #2;
                check_eq("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
                check_eq("bp_out_valid", {31'b0, out_valid}, 32'd1);
                repeat (5) @(posedge clk);
                #2 out_ready = 1'b1;
            end
        join
        wait_drain();

        // reset with operations in flight
        send_m(24'h9ABCDE, 24'h800000, 8'd140, 8'd2, 1'b0, 1'b0);
        send_m(24'hFEDCBA, 24'h876543, 8'd141, 8'd4, 1'b1, 1'b1);
        rstn = 1'b0;
        exp_q.delete();
        #1;
        check_eq("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("midrst_result", result, 32'h0);
        check_eq("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        send(24'h800000, 24'h800000, 8'd127, 8'd0, 1'b0, 1'b0, 32'h40000000);
        wait_drain();

        // random traffic with random bubbles and random backpressure
        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    logic [23:0] a, b;
                    logic [7:0]  e, d;
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    a = {1'b1, 23'($urandom)};
                    b = {1'b1, 23'($urandom)};
                    if ($urandom_range(0, 7) == 0)
                        e = ($urandom_range(0, 1) == 1) ? 8'd254 : 8'($urandom_range(1, 26));
                    else
                        e = 8'($urandom_range(1, 254));
                    if ($urandom_range(0, 3) == 0) d = 8'($urandom_range(0, 3));
                    else                           d = 8'($urandom_range(0, 34));
                    send_m(a, b, e, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #2;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
